// File: rtl/game_phase_ctrl.sv
// Game phase controller: color selection, board-initialization handshake with
// timeout/retry, play and game-over phases. All outputs are registered Moore decodes.
module game_phase_ctrl #(
  parameter int unsigned INIT_TIMEOUT   = 1024,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned DEFAULT_COLORS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       init_done,
  input  logic       game_over,
  output logic [3:0] final_COLOR_NUM,
  output logic       BEGIN_GAME,
  output logic       INITIALIZE_BOARD,
  output logic       ACK_BEGIN_GAME,
  output logic       INIT_INIT,
  output logic       init_fail
);

  typedef enum logic [2:0] {
    S_SELECT = 3'd0,
    S_ACK    = 3'd1,
    S_CLEAR  = 3'd2,
    S_INIT   = 3'd3,
    S_PLAY   = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [15:0] TMO_LAST  = 16'(INIT_TIMEOUT - 1);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [3:0]  COLOR_RST = 4'(DEFAULT_COLORS);
  localparam logic [3:0]  COLOR_MAX = 4'd8;
  localparam logic [3:0]  COLOR_MIN = 4'd3;

  state_t      state_q, state_d;
  logic [3:0]  color_q, color_d;
  logic [1:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;
  logic        fail_q, fail_d;
  logic [1:0]  retry_inc_s;

  assign retry_inc_s = retry_q + 2'd1;

  always_comb begin
    state_d = state_q;
    color_d = color_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    fail_d  = fail_q;
    case (state_q)
      S_SELECT: begin
        // Color change is applied even when start arrives in the same cycle.
        if (btn_up && !btn_down && (color_q < COLOR_MAX)) begin
          color_d = color_q + 4'd1;
        end else if (btn_down && !btn_up && (color_q > COLOR_MIN)) begin
          color_d = color_q - 4'd1;
        end else begin
          color_d = color_q;
        end
        if (btn_start) begin
          state_d = S_ACK;
          fail_d  = 1'b0;
          retry_d = 2'd0;
        end else begin
          state_d = S_SELECT;
        end
      end
      S_ACK: begin
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        tmo_d   = 16'd0;
        state_d = S_INIT;
      end
      S_INIT: begin
        tmo_d = tmo_q + 16'd1;
        if (init_done) begin
          state_d = S_PLAY;
        end else if (tmo_q == TMO_LAST) begin
          retry_d = retry_inc_s;
          if (retry_inc_s < RETRY_MAX) begin
            state_d = S_CLEAR;
          end else begin
            fail_d  = 1'b1;
            state_d = S_SELECT;
          end
        end else begin
          state_d = S_INIT;
        end
      end
      S_PLAY: begin
        if (game_over) begin
          state_d = S_OVER;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_OVER: begin
        if (btn_start) begin
          state_d = S_SELECT;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_SELECT;
      end
    endcase
  end

  // Outputs are registered from the next state so each equals a decode of state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_SELECT;
      color_q          <= COLOR_RST;
      retry_q          <= 2'd0;
      tmo_q            <= 16'd0;
      fail_q           <= 1'b0;
      BEGIN_GAME       <= 1'b0;
      INITIALIZE_BOARD <= 1'b0;
      ACK_BEGIN_GAME   <= 1'b0;
      INIT_INIT        <= 1'b0;
    end else begin
      state_q          <= state_d;
      color_q          <= color_d;
      retry_q          <= retry_d;
      tmo_q            <= tmo_d;
      fail_q           <= fail_d;
      BEGIN_GAME       <= (state_d == S_PLAY);
      INITIALIZE_BOARD <= (state_d == S_INIT);
      ACK_BEGIN_GAME   <= (state_d == S_ACK);
      INIT_INIT        <= (state_d == S_CLEAR);
    end
  end

  assign final_COLOR_NUM = color_q;
  assign init_fail       = fail_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed self-checking bench for game_phase_ctrl: one default instance and one
// with a short init timeout, both driven by the same stimulus.
module tb_game_phase_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic init_done = 1'b0, game_over = 1'b0;

  logic [3:0] col_a, col_b;
  logic bg_a, ib_a, ack_a, ii_a, fail_a;
  logic bg_b, ib_b, ack_b, ii_b, fail_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .init_done(init_done), .game_over(game_over),
    .final_COLOR_NUM(col_a), .BEGIN_GAME(bg_a), .INITIALIZE_BOARD(ib_a),
    .ACK_BEGIN_GAME(ack_a), .INIT_INIT(ii_a), .init_fail(fail_a)
  );

  game_phase_ctrl #(.INIT_TIMEOUT(8)) dut_t (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .init_done(init_done), .game_over(game_over),
    .final_COLOR_NUM(col_b), .BEGIN_GAME(bg_b), .INITIALIZE_BOARD(ib_b),
    .ACK_BEGIN_GAME(ack_b), .INIT_INIT(ii_b), .init_fail(fail_b)
  );

  // Observed vector: {color[3:0], BEGIN_GAME, INITIALIZE_BOARD, ACK, INIT_INIT, init_fail}
  wire [8:0] out_a = {col_a, bg_a, ib_a, ack_a, ii_a, fail_a};
  wire [8:0] out_b = {col_b, bg_b, ib_b, ack_b, ii_b, fail_b};

  // Control strobes must be mutually exclusive on every cycle of every scenario.
  always @(negedge clk) begin
    n_vec++;
    if ($countones({bg_a, ib_a, ack_a, ii_a}) > 1 || $countones({bg_b, ib_b, ack_b, ii_b}) > 1) begin
      n_err++;
      $display("FAIL exclusive @%0t: got a=%b b=%b want at most one strobe", $time, out_a[4:1], out_b[4:1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    {btn_up, btn_down, btn_start, init_done, game_over} = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (out_a !== {4'd6, 5'b00000} || out_b !== {4'd6, 5'b00000}) begin
      n_err++;
      $display("FAIL reset_state: got a=%b b=%b want %b", out_a, out_b, {4'd6, 5'b00000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (out_a !== {4'd6, 5'b00000}) begin
      n_err++;
      $display("FAIL reset_release: got %b want %b", out_a, {4'd6, 5'b00000});
    end
  endtask

  task automatic test_colors();
    int exp_up[3] = '{7, 8, 8};
    int exp_dn[6] = '{7, 6, 5, 4, 3, 3};
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
      n_vec++;
      if (out_a !== {4'(exp_up[i]), 5'b00000}) begin
        n_err++;
        $display("FAIL color_up[%0d]: got %b want %b", i, out_a, {4'(exp_up[i]), 5'b00000});
      end
    end
    for (int i = 0; i < 6; i++) begin
      btn_down = 1'b1;
      tick();
      btn_down = 1'b0;
      n_vec++;
      if (out_a !== {4'(exp_dn[i]), 5'b00000}) begin
        n_err++;
        $display("FAIL color_down[%0d]: got %b want %b", i, out_a, {4'(exp_dn[i]), 5'b00000});
      end
    end
    btn_up = 1'b1;
    tick();
    btn_down = 1'b1;
    tick();
    {btn_up, btn_down} = 2'b00;
    n_vec++;
    if (out_a !== {4'd4, 5'b00000}) begin
      n_err++;
      $display("FAIL color_both: got %b want %b", out_a, {4'd4, 5'b00000});
    end
  endtask

  task automatic test_start_latency();
    btn_start = 1'b1;
    btn_up    = 1'b1;
    tick();
    {btn_start, btn_up} = 2'b00;
    n_vec++;
    if (out_a !== {4'd5, 5'b00100}) begin
      n_err++;
      $display("FAIL start_ack: got %b want %b", out_a, {4'd5, 5'b00100});
    end
    tick();
    n_vec++;
    if (out_a !== {4'd5, 5'b00010}) begin
      n_err++;
      $display("FAIL start_clear: got %b want %b", out_a, {4'd5, 5'b00010});
    end
    for (int j = 2; j <= 10; j++) begin
      tick();
      n_vec++;
      if (out_a !== {4'd5, 5'b01000}) begin
        n_err++;
        $display("FAIL start_init[k+%0d]: got %b want %b", j, out_a, {4'd5, 5'b01000});
      end
    end
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    n_vec++;
    if (out_a !== {4'd5, 5'b10000}) begin
      n_err++;
      $display("FAIL start_play: got %b want %b", out_a, {4'd5, 5'b10000});
    end
  endtask

  task automatic test_play_over();
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    n_vec++;
    if (out_a !== {4'd5, 5'b10000}) begin
      n_err++;
      $display("FAIL play_ignore: got %b want %b", out_a, {4'd5, 5'b10000});
    end
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    n_vec++;
    if (out_a !== {4'd5, 5'b00000}) begin
      n_err++;
      $display("FAIL game_over: got %b want %b", out_a, {4'd5, 5'b00000});
    end
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    tick();
    n_vec++;
    if (out_a !== {4'd5, 5'b00000}) begin
      n_err++;
      $display("FAIL over_hold: got %b want %b", out_a, {4'd5, 5'b00000});
    end
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    n_vec++;
    if (out_a !== {4'd5, 5'b00000}) begin
      n_err++;
      $display("FAIL over_exit: got %b want %b", out_a, {4'd5, 5'b00000});
    end
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    n_vec++;
    if (out_a !== {4'd6, 5'b00000}) begin
      n_err++;
      $display("FAIL select_again: got %b want %b", out_a, {4'd6, 5'b00000});
    end
  endtask

  task automatic test_timeout();
    logic [8:0] exp_v;
    logic ib_e;
    do_reset();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    for (int i = 0; i <= 28; i++) begin
      if (i > 0) tick();
      ib_e  = (i >= 2 && i <= 9) || (i >= 11 && i <= 18) || (i >= 20 && i <= 27);
      exp_v = {4'd6, 1'b0, ib_e, (i == 0), (i == 1 || i == 10 || i == 19), (i >= 28)};
      n_vec++;
      if (out_b !== exp_v) begin
        n_err++;
        $display("FAIL timeout[%0d]: got %b want %b", i, out_b, exp_v);
      end
    end
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    n_vec++;
    if (out_b !== {4'd6, 5'b00100}) begin
      n_err++;
      $display("FAIL fail_clear: got %b want %b", out_b, {4'd6, 5'b00100});
    end
  endtask

  task automatic test_reset_mid_init();
    do_reset();
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    tick();
    tick();
    n_vec++;
    if (out_a !== {4'd7, 5'b01000}) begin
      n_err++;
      $display("FAIL mid_init: got %b want %b", out_a, {4'd7, 5'b01000});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_a !== {4'd6, 5'b00000}) begin
      n_err++;
      $display("FAIL async_reset: got %b want %b", out_a, {4'd6, 5'b00000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (out_a !== {4'd6, 5'b00000}) begin
      n_err++;
      $display("FAIL release_quiet: got %b want %b", out_a, {4'd6, 5'b00000});
    end
  endtask

  initial begin
    test_reset();
    test_colors();
    test_start_latency();
    test_play_over();
    test_timeout();
    test_reset_mid_init();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
